// File: rtl/regdst_queue.sv
// Selects one of NUM_IN destination indices and queues it in a DEPTH-entry write-back FIFO.
// Latency: a push is visible on dst_head one cycle later (no bypass); hazard flags are combinational.
// Backpressure: a push while full is dropped (ovf) unless a pop happens in the same cycle; a pop while empty is ignored (udf).
// Optional feature macro: HAZARD_CHECK_EN enables source-register hazard comparators.
module regdst_queue #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      dst_load,
  input  logic                      wb_done,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          rs_addr,
  input  logic [WIDTH-1:0]          rt_addr,
  output logic [WIDTH-1:0]          dst_head,
  output logic                      head_valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      sel_err,
  output logic                      ovf,
  output logic                      udf,
  output logic                      hazard_rs,
  output logic                      hazard_rt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SEL_W:0] NUM_IN_L = NUM_IN[SEL_W:0];
  localparam logic [CW-1:0]  DEPTH_L  = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sel_err_q, sel_err_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             sel_ok;
  logic [WIDTH-1:0] sel_dat;
  logic             full_w, empty_w;
  logic             push, pop;

  assign sel_ok  = ({1'b0, sel} < NUM_IN_L);
  assign full_w  = (count_q == DEPTH_L);
  assign empty_w = (count_q == '0);

  // A flush cycle neither pushes nor pops, and a pop on an empty queue is never honoured.
  assign push = !flush && dst_load && (!full_w || wb_done);
  assign pop  = !flush && wb_done && !empty_w;

  // Candidate mux; out-of-range selects yield index 0.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == i[SEL_W-1:0]) sel_dat = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sel_err_d = sel_err_q | (push && !sel_ok);
    ovf_d     = ovf_q | (!flush && dst_load && full_w && !wb_done);
    udf_d     = udf_q | (!flush && wb_done && empty_w);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sel_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sel_err_q <= sel_err_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage needs no reset: slots are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sel_dat;
  end

  assign dst_head   = empty_w ? '0 : mem_q[rd_ptr_q];
  assign head_valid = !empty_w;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign sel_err    = sel_err_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

`ifdef HAZARD_CHECK_EN
  logic          hz_rs, hz_rt;
  logic [PW-1:0] slot;

  // Compare sources against occupied slots only, walking from the head; $zero never matches.
  always_comb begin
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + k[PW-1:0];
      if (k[CW-1:0] < count_q) begin
        if ((rs_addr != '0) && (mem_q[slot] == rs_addr)) hz_rs = 1'b1;
        if ((rt_addr != '0) && (mem_q[slot] == rt_addr)) hz_rt = 1'b1;
      end
    end
  end

  assign hazard_rs = hz_rs;
  assign hazard_rt = hz_rt;
`else
  logic unused_src;
  assign unused_src = ^{rs_addr, rt_addr};
  assign hazard_rs  = 1'b0;
  assign hazard_rt  = 1'b0;
`endif

endmodule

// File: tb/tb_regdst_queue.sv
// Bench for regdst_queue: stimulus feeds a queue-based reference model, a negedge monitor checks outputs.
module tb_regdst_queue;

  localparam int WIDTH  = 5;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;
  localparam int DEPTH  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]        sel;
  logic                    dst_load, wb_done, flush;
  logic [WIDTH-1:0]        rs_addr, rt_addr;
  logic [WIDTH-1:0]        dst_head;
  logic                    head_valid, full, empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    sel_err, ovf, udf, hazard_rs, hazard_rt;

  regdst_queue #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .dst_load(dst_load),
    .wb_done(wb_done), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .dst_head(dst_head), .head_valid(head_valid), .full(full), .empty(empty),
    .count(count), .sel_err(sel_err), .ovf(ovf), .udf(udf),
    .hazard_rs(hazard_rs), .hazard_rt(hazard_rt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue of pending destinations plus sticky flags.
  int exp_q[$];
  bit m_sel_err, m_ovf, m_udf;
  bit pend_push, pend_fl, pend_sel_err, pend_ovf, pend_udf;
  int pend_val;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares all outputs against the model and retires the head on each pop.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      automatic int sz = exp_q.size();
      automatic bit hz_rs = 1'b0;
      automatic bit hz_rt = 1'b0;
      foreach (exp_q[i]) begin
        if (rs_addr != 0 && exp_q[i] == int'(rs_addr)) hz_rs = 1'b1;
        if (rt_addr != 0 && exp_q[i] == int'(rt_addr)) hz_rt = 1'b1;
      end
`ifndef HAZARD_CHECK_EN
      hz_rs = 1'b0;
      hz_rt = 1'b0;
`endif
      check("count", int'(count), sz);
      check("empty", int'(empty), int'(sz == 0));
      check("full", int'(full), int'(sz == DEPTH));
      check("head_valid", int'(head_valid), int'(sz != 0));
      check("dst_head", int'(dst_head), (sz != 0) ? exp_q[0] : 0);
      check("sel_err", int'(sel_err), int'(m_sel_err));
      check("ovf", int'(ovf), int'(m_ovf));
      check("udf", int'(udf), int'(m_udf));
      check("hazard_rs", int'(hazard_rs), int'(hz_rs));
      check("hazard_rt", int'(hazard_rt), int'(hz_rt));
      if (wb_done && head_valid && !flush) begin
        if (sz == 0) check("pop_underrun", 1, 0);
        else void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus: retire last cycle's model effects, drive new inputs, predict effects.
  task automatic step(input bit ld, input int s, input bit dn, input bit fl,
                      input logic [NUM_IN*WIDTH-1:0] din, input int rs, input int rt);
    int sz;
    @(posedge clk);
    #1;
    if (pend_fl) exp_q.delete();
    if (pend_push) exp_q.push_back(pend_val);
    m_sel_err |= pend_sel_err;
    m_ovf     |= pend_ovf;
    m_udf     |= pend_udf;
    dst_load = ld;
    sel      = s[SEL_W-1:0];
    wb_done  = dn;
    flush    = fl;
    data_in  = din;
    rs_addr  = rs[WIDTH-1:0];
    rt_addr  = rt[WIDTH-1:0];
    sz = exp_q.size();
    pend_fl      = fl;
    pend_push    = !fl && ld && (sz < DEPTH || dn);
    pend_val     = (s < NUM_IN) ? int'(din[s*WIDTH +: WIDTH]) : 0;
    pend_sel_err = pend_push && (s >= NUM_IN);
    pend_ovf     = !fl && ld && (sz == DEPTH) && !dn;
    pend_udf     = !fl && dn && (sz == 0);
  endtask

  logic [NUM_IN*WIDTH-1:0] dvec;
  logic [NUM_IN*WIDTH-1:0] hvec;

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (simulation did not complete)");
    $fatal(1, "timeout");
  end

  initial begin
    dvec = {5'd31, 5'd9, 5'd8, 5'd7, 5'd6};
    hvec = {5'd0, 5'd0, 5'd0, 5'd0, 5'd9};
    reset = 1'b1; data_in = '0; sel = '0; dst_load = 1'b0; wb_done = 1'b0;
    flush = 1'b0; rs_addr = '0; rt_addr = '0;
    #12;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_head", int'(dst_head), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 mon_en = 1'b1;

    // Three entries pending, then reset lands mid-cycle.
    for (int i = 0; i < 3; i++) step(1, i, 0, 0, dvec, 0, 0);
    step(0, 0, 0, 0, dvec, 0, 0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("midrst_count", int'(count), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_head", int'(dst_head), 0);
    check("midrst_valid", int'(head_valid), 0);
    check("midrst_flags", int'({sel_err, ovf, udf}), 0);
    exp_q.delete();
    {pend_push, pend_fl, pend_sel_err, pend_ovf, pend_udf} = '0;
    {m_sel_err, m_ovf, m_udf} = '0;
    @(negedge clk);
    reset = 1'b0;
    #1 mon_en = 1'b1;

    // Fill to DEPTH, drain in order.
    for (int i = 0; i < 4; i++) step(1, i, 0, 0, dvec, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, dvec, 0, 0);
    step(0, 0, 0, 0, dvec, 0, 0);

    // Full: push+pop keeps count, push alone overflows, then flush.
    for (int i = 0; i < 4; i++) step(1, i, 0, 0, dvec, 0, 0);
    step(1, 4, 1, 0, dvec, 0, 0);
    step(1, 2, 0, 0, dvec, 0, 0);
    step(0, 0, 0, 0, dvec, 0, 0);
    step(0, 0, 0, 1, dvec, 0, 0);

    // Bad select pushes 0; pop on empty underflows.
    step(1, 5, 0, 0, dvec, 0, 0);
    step(0, 0, 1, 0, dvec, 0, 0);
    step(0, 0, 1, 0, dvec, 0, 0);
    step(0, 0, 0, 0, dvec, 0, 0);

    // Wrap across slot 3 -> 0 with simultaneous push/pop, then flush with load.
    step(1, 0, 0, 0, dvec, 0, 0);
    for (int i = 0; i < 6; i++) step(1, (i % 4), 1, 0, dvec, 0, 0);
    step(1, 1, 0, 1, dvec, 0, 0);
    step(0, 0, 0, 0, dvec, 0, 0);

    // Hazards: pending {9,0}; rs=9 hits, rt=0 never hits.
    step(1, 0, 0, 0, hvec, 0, 0);
    step(1, 1, 0, 0, hvec, 0, 0);
    step(0, 0, 0, 0, hvec, 9, 0);
    step(0, 0, 1, 0, hvec, 9, 0);
    step(0, 0, 0, 0, hvec, 9, 0);
    step(0, 0, 1, 0, hvec, 9, 0);
    step(0, 0, 0, 0, hvec, 9, 0);

    // Randomized traffic; small index range raises hazard hit rate.
    for (int n = 0; n < 600; n++) begin
      automatic logic [NUM_IN*WIDTH-1:0] d;
      automatic bit fl = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NUM_IN; c++)
        d[c*WIDTH +: WIDTH] = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 7))
                                                           : WIDTH'($urandom);
      if (fl) step(0, 0, 0, 1, d, 0, 0);
      else step(($urandom_range(0, 2) != 0), $urandom_range(0, 7), ($urandom_range(0, 1) != 0),
                0, d, $urandom_range(0, 7), $urandom_range(0, 7));
    end
    step(0, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0);
    @(posedge clk);
    #1 mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
